// File: rtl/mdio_link_poller.sv
// mdio_link_poller: periodic MDIO link-status scanner over NUM_PORTS PHYs; define LINK_DEBOUNCE_EN for two-scan link debounce
module mdio_link_poller #(
  parameter int NUM_PORTS      = 4,
  parameter int PHY_BASE       = 0,
  parameter int REG_ADDR       = 1,
  parameter int LINK_BIT       = 2,
  parameter int POLL_CYCLES    = 1250000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 poll_en,
  input  logic                 work_bit,
  input  logic                 sta_enb,
  input  logic [15:0]          data_sta,
  output logic                 req_enb,
  output logic [1:0]           req_op,
  output logic [4:0]           phy_addr,
  output logic [4:0]           reg_addr,
  output logic [NUM_PORTS-1:0] port_link,
  output logic                 link_change,
  output logic                 scan_done,
  output logic [NUM_PORTS-1:0] timeout_err
);
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int TW = $clog2(POLL_CYCLES);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, WAIT_DATA, NEXT} state_t;
  state_t               state;
  logic [IW-1:0]        idx;
  logic [TW-1:0]        timer;
  logic [CW-1:0]        tcnt;
  logic                 tick, to_hit, got, hit, rd;
  logic [NUM_PORTS-1:0] link_n;
  logic                 unused;
  assign unused   = ^data_sta;
  assign req_op   = 2'b10;
  assign reg_addr = 5'(REG_ADDR);
`ifdef LINK_DEBOUNCE_EN
  logic [NUM_PORTS-1:0] pend, pend_n;
  // pend[i] remembers that the previous scan read the opposite of port_link[i]
  always_ff @(posedge clk) pend <= reset ? '0 : pend_n;
`endif
  // poll tick, access outcome and next link vector for the port being read
  always_comb begin
    tick   = poll_en && timer == TW'(POLL_CYCLES - 1);
    to_hit = (state == WAIT_ACK || state == WAIT_DATA) && tcnt == CW'(TIMEOUT_CYCLES - 1);
    got    = state == WAIT_DATA && sta_enb;
    hit    = got || to_hit;
    rd     = got && data_sta[LINK_BIT];
    link_n = port_link;
`ifdef LINK_DEBOUNCE_EN
    pend_n = pend;
    if (hit) begin
      link_n[idx] = (rd != port_link[idx] && pend[idx]) ? rd : port_link[idx];
      pend_n[idx] = rd != port_link[idx] && !pend[idx];
    end
`else
    if (hit) link_n[idx] = rd;
`endif
  end
  // scan sequencer, poll timer, access timeout and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      tcnt        <= '0;
      req_enb     <= 1'b0;
      phy_addr    <= 5'(PHY_BASE);
      port_link   <= '0;
      link_change <= 1'b0;
      scan_done   <= 1'b0;
      timeout_err <= '0;
    end else begin
      timer       <= (tick || !poll_en) ? '0 : timer + TW'(1);
      tcnt        <= (state == WAIT_ACK || state == WAIT_DATA) ? tcnt + CW'(1) : '0;
      port_link   <= link_n;
      link_change <= link_n != port_link;
      scan_done   <= 1'b0;
      if (hit) timeout_err[idx] <= !got;
      case (state)
        IDLE: if (tick && !work_bit) begin
          state <= REQ;
          idx   <= '0;
        end
        REQ: if (!work_bit) begin
          phy_addr <= 5'(PHY_BASE) + 5'(idx);
          req_enb  <= 1'b1;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: if (to_hit || work_bit) begin
          req_enb <= 1'b0;
          state   <= to_hit ? NEXT : WAIT_DATA;
        end
        WAIT_DATA: if (hit) state <= NEXT;
        NEXT: if (idx == IW'(NUM_PORTS - 1)) begin
          scan_done <= 1'b1;
          state     <= IDLE;
        end else begin
          idx   <= idx + IW'(1);
          state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_link_poller.sv
// tb_mdio_link_poller: randomized scoreboard bench for mdio_link_poller with a PHY model and per-scan reference model
module tb_mdio_link_poller;
  localparam int NP = 4, PB = 0, RA = 1, LB = 2, PC = 100, TO = 16;
  logic clk = 0, reset = 1, poll_en = 0, phy_busy = 0, ext_busy = 0, sta_enb = 0;
  logic [15:0] data_sta = 0;
  logic req_enb, link_change, scan_done;
  logic [1:0] req_op;
  logic [4:0] phy_addr, reg_addr;
  logic [NP-1:0] port_link, timeout_err;
  int errors = 0, checks = 0, n_req = 0, n_done = 0;
  logic [15:0] phy_data [32];
  int phy_mute [32];
  typedef struct {logic [NP-1:0] link; logic [NP-1:0] err; int nchg;} exp_t;
  int addr_q [$];
  exp_t scan_q [$];
  bit m_link [NP];
  bit m_pend [NP];

  always #5 clk = ~clk;

  mdio_link_poller #(.NUM_PORTS(NP), .PHY_BASE(PB), .REG_ADDR(RA), .LINK_BIT(LB),
                     .POLL_CYCLES(PC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .poll_en(poll_en), .work_bit(phy_busy | ext_busy),
    .sta_enb(sta_enb), .data_sta(data_sta), .req_enb(req_enb), .req_op(req_op),
    .phy_addr(phy_addr), .reg_addr(reg_addr), .port_link(port_link),
    .link_change(link_change), .scan_done(scan_done), .timeout_err(timeout_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_req_enb", req_enb, 0);
    chk("rst_req_op", req_op, 2'b10);
    chk("rst_phy_addr", phy_addr, PB);
    chk("rst_reg_addr", reg_addr, RA);
    chk("rst_port_link", port_link, 0);
    chk("rst_link_change", link_change, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  // reference model: one scan reads each port once; a muted PHY counts as a timed-out read of 0
  task automatic push_scan();
    exp_t e;
    e.nchg = 0;
    for (int i = 0; i < NP; i++) begin
      int a;
      bit v, old;
      a = (PB + i) % 32;
      addr_q.push_back(a);
      v = (phy_mute[a] != 0) ? 1'b0 : phy_data[a][LB];
      old = m_link[i];
`ifdef LINK_DEBOUNCE_EN
      if (v == m_link[i]) m_pend[i] = 0;
      else if (m_pend[i]) begin m_link[i] = v; m_pend[i] = 0; end
      else m_pend[i] = 1;
`else
      m_link[i] = v;
`endif
      if (m_link[i] != old) e.nchg++;
      e.link[i] = m_link[i];
      e.err[i] = phy_mute[a] != 0;
    end
    scan_q.push_back(e);
  endtask

  // PHY model: mute 0 normal, 1 never acks, 2 acks but never returns data, 3 returns data very late
  initial begin
    int a, m, k;
    forever begin
      @(posedge clk); #1;
      if (req_enb && !reset) begin
        a = int'(phy_addr);
        m = phy_mute[a];
        if (m != 1) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          phy_busy = 1;
        end
        k = 0;
        while (req_enb && k < 200) begin @(posedge clk); #1; k++; end
        if (m != 1) begin
          repeat (m == 3 ? 8 : $urandom_range(1, 4)) begin @(posedge clk); #1; end
          phy_busy = 0;
          if (m == 0 || m == 3) begin
            sta_enb = 1;
            data_sta = phy_data[a];
            @(posedge clk); #1;
            sta_enb = 0;
          end
        end
      end
      data_sta = 16'($urandom);
    end
  end

  // monitor: pops expected addresses on each request and expected scan results on each scan_done
  int hi_cnt = 0, dur_exp = 0, chg_cnt = 0, mon_a = 0;
  logic req_prev = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      chg_cnt = 0;
      req_prev = 0;
      dur_exp = 0;
    end else begin
      if (req_enb && !req_prev) begin
        n_req++;
        hi_cnt = 0;
        chk("req_op", req_op, 2'b10);
        chk("reg_addr", reg_addr, RA);
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got request to phy %0d, expected none", phy_addr);
          dur_exp = 0;
        end else begin
          mon_a = addr_q.pop_front();
          chk("phy_addr", phy_addr, mon_a);
          dur_exp = phy_mute[mon_a] == 1 ? TO : 0;
        end
      end
      if (req_enb) hi_cnt++;
      if (!req_enb && req_prev && dur_exp != 0) chk("timeout_req_len", hi_cnt, dur_exp);
      if (link_change) chg_cnt++;
      if (scan_done) begin
        n_done++;
        if (scan_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_scan_done: got scan_done, expected none");
        end else begin
          mon_e = scan_q.pop_front();
          chk("port_link", port_link, mon_e.link);
          chk("timeout_err", timeout_err, mon_e.err);
          chk("link_change_count", chg_cnt, mon_e.nchg);
        end
        chg_cnt = 0;
      end
      req_prev = req_enb;
    end
  end

  task automatic run_scan(input int start_exp, input int busy_until, input int drop);
    int n;
    push_scan();
    ext_busy = busy_until > 0;
    poll_en = 1;
    n = 0;
    while (!req_enb && n < 4 * PC) begin
      @(posedge clk); #1; n++;
      if (n == busy_until) ext_busy = 0;
    end
    chk("start_latency", n, start_exp);
    n = 0;
    while (!(req_enb && phy_addr == 5'((PB + drop) % 32)) && n < 500) begin @(posedge clk); #1; n++; end
    poll_en = 0;
    n = 0;
    while (!scan_done && n < 1000) begin @(posedge clk); #1; n++; end
    chk("scan_done_seen", scan_done, 1);
    @(posedge clk); #1;
    ext_busy = 0;
  endtask

  initial begin
    int n, r, d;
    logic [15:0] v;
    for (int i = 0; i < 32; i++) begin phy_data[i] = 0; phy_mute[i] = 0; end
    for (int i = 0; i < NP; i++) begin m_link[i] = 0; m_pend[i] = 0; end
    repeat (3) @(posedge clk); #1;
    chk_reset();
    reset = 0;
    phy_data[0] = 16'h0004; phy_data[2] = 16'h0004;
    run_scan(PC + 1, 0, $urandom_range(0, 3));
    phy_mute[1] = 1;
    run_scan(PC + 1, 0, 1);
    phy_mute[1] = 0;
    run_scan(2 * PC + 1, 150, 0);
    run_scan(PC + 1, 0, 2);
    r = n_req; d = n_done;
    repeat (5 * PC) @(posedge clk); #1;
    chk("quiet_req", n_req, r);
    chk("quiet_done", n_done, d);
    for (int s = 0; s < 4; s++) begin
      for (int i = 1; i < NP; i++) phy_data[(PB + i) % 32] = 16'($urandom);
      v = 16'($urandom);
      v[LB] = s != 1;
      phy_data[PB % 32] = v;
      run_scan(PC + 1, 0, $urandom_range(0, 3));
    end
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < NP; i++) begin
        phy_data[(PB + i) % 32] = 16'($urandom);
        phy_mute[(PB + i) % 32] = $urandom_range(0, 9) < 2 ? $urandom_range(1, 2) : 0;
      end
      run_scan(PC + 1, 0, $urandom_range(0, 3));
    end
    for (int i = 0; i < 32; i++) phy_mute[i] = 0;
    phy_data[PB % 32] = 16'h0004;
    phy_data[(PB + 1) % 32] = 16'h0004;
    phy_mute[(PB + 1) % 32] = 3;
    addr_q.push_back(PB % 32);
    addr_q.push_back((PB + 1) % 32);
    poll_en = 1;
    n = 0;
    while (!(req_enb && phy_addr == 5'((PB + 1) % 32)) && n < 500) begin @(posedge clk); #1; n++; end
    poll_en = 0;
    n = 0;
    while (req_enb && n < 100) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    chk_reset();
    reset = 0;
    for (int i = 0; i < NP; i++) begin m_link[i] = 0; m_pend[i] = 0; end
    d = n_done;
    repeat (40) @(posedge clk); #1;
    chk("post_reset_link", port_link, 0);
    chk("post_reset_err", timeout_err, 0);
    chk("post_reset_no_done", n_done, d);
    chk("reset_reqs_consumed", addr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no completion, expected finish within 60000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
